// File: rtl/bht_pkg.sv
// bht_pkg: shared types and helpers for the branch history table predictor.
//   - 2-bit saturating counter encodings (SNT/WNT/WT/ST)
//   - ADDR_W: word-address width of the instruction PC
//   - q_entry_t: one outstanding prediction {pc, predicted, target}
//   - ctr_update(): saturating counter training step
package bht_pkg;

  localparam int ADDR_W = 5;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic              predicted;
    logic [ADDR_W-1:0] target;
  } q_entry_t;

  // Taken moves toward ST, not-taken toward SNT; both ends saturate.
  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != ST) nxt = ctr + 2'b01;
      else           nxt = ctr;
    end else begin
      if (ctr != SNT) nxt = ctr - 2'b01;
      else            nxt = ctr;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pred_fifo.sv
// pred_fifo: in-order queue of outstanding branch predictions.
//   clk, reset   : clock, asynchronous active-high reset
//   clr_i        : synchronous clear (wrong-path flush), wins over push/pop
//   push_i/data_i: enqueue one entry (caller guarantees not full)
//   pop_i        : dequeue the head (caller guarantees not empty)
//   head_o       : oldest entry
//   count_o      : number of stored entries, 0..DEPTH
module pred_fifo
  import bht_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          push_i,
  input  q_entry_t      data_i,
  input  logic          pop_i,
  output q_entry_t      head_o,
  output logic [PW:0]   count_o
);

  q_entry_t    mem_q [DEPTH];
  logic [PW:0] wr_q;
  logic [PW:0] rd_q;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q[PW-1:0]] <= data_i;
        wr_q                <= wr_q + 1'b1;
      end
      if (pop_i) begin
        rd_q <= rd_q + 1'b1;
      end
    end
  end

  assign head_o  = mem_q[rd_q[PW-1:0]];
  assign count_o = wr_q - rd_q;

endmodule

// File: rtl/bht_predictor.sv
// bht_predictor: 2-bit saturating-counter branch predictor ahead of fetch.
//   fetch_*          : branch lookup; predict_taken/predict_target are combinational
//   resolve_*        : execute outcome for the oldest outstanding branch
//   mispredict       : registered one-cycle flush pulse, with redirect_pc
//   queue_full       : fetch must stall branches while high
//   pending          : outstanding prediction count
module bht_predictor #(
  parameter int ADDR_W  = bht_pkg::ADDR_W,
  parameter int ENTRIES = 32,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_valid,
  input  logic [ADDR_W-1:0]        fetch_pc,
  input  logic                     fetch_is_branch,
  input  logic [ADDR_W-1:0]        fetch_target,
  output logic                     predict_taken,
  output logic [ADDR_W-1:0]        predict_target,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  output logic                     mispredict,
  output logic [ADDR_W-1:0]        redirect_pc,
  output logic                     queue_full,
  output logic [$clog2(DEPTH):0]   pending
);

  import bht_pkg::*;

  localparam int          PW       = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [1:0]        table_q [ENTRIES];
  logic              mispredict_q;
  logic [ADDR_W-1:0] redirect_q;

  q_entry_t          head_s;
  q_entry_t          push_data_s;
  logic              do_pop_s;
  logic              do_push_s;
  logic              mis_s;
  logic [ADDR_W-1:0] redirect_d;

  // Lookup, queue control and the correct next PC for a wrong prediction.
  always_comb begin
    predict_taken  = fetch_valid & fetch_is_branch & table_q[fetch_pc][1];
    predict_target = predict_taken ? fetch_target : fetch_pc + ADDR_W'(1);
    do_pop_s       = resolve_valid & (pending != '0);
    mis_s          = do_pop_s & (resolve_taken != head_s.predicted);
    // The queue_full test uses registered state, so a pop never frees a slot
    // for a push in the same cycle.
    do_push_s      = fetch_valid & fetch_is_branch & ~queue_full & ~mispredict_q;
    push_data_s    = '{pc: fetch_pc, predicted: predict_taken, target: fetch_target};
    redirect_d     = resolve_taken ? head_s.target : head_s.pc + ADDR_W'(1);
  end

  // A mispredicting pop flushes the whole queue, including any same-cycle push.
  pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (mis_s),
    .push_i  (do_push_s & ~mis_s),
    .data_i  (push_data_s),
    .pop_i   (do_pop_s),
    .head_o  (head_s),
    .count_o (pending)
  );

  // Counter table training and the registered flush/redirect outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= WNT;
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
    end else begin
      mispredict_q <= mis_s;
      if (mis_s) redirect_q <= redirect_d;
      if (do_pop_s) table_q[head_s.pc] <= ctr_update(table_q[head_s.pc], resolve_taken);
    end
  end

  assign mispredict  = mispredict_q;
  assign redirect_pc = redirect_q;
  assign queue_full  = (pending == FULL_CNT);

endmodule

// File: tb/tb_bht_predictor.sv
module tb_bht_predictor;

  logic       clk = 1'b0;
  logic       reset;
  logic       fetch_valid;
  logic [4:0] fetch_pc;
  logic       fetch_is_branch;
  logic [4:0] fetch_target;
  logic       predict_taken;
  logic [4:0] predict_target;
  logic       resolve_valid;
  logic       resolve_taken;
  logic       mispredict;
  logic [4:0] redirect_pc;
  logic       queue_full;
  logic [2:0] pending;

  int total = 0;
  int bad   = 0;

  bht_predictor #(.ADDR_W(5), .ENTRIES(32), .DEPTH(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_valid     (fetch_valid),
    .fetch_pc        (fetch_pc),
    .fetch_is_branch (fetch_is_branch),
    .fetch_target    (fetch_target),
    .predict_taken   (predict_taken),
    .predict_target  (predict_target),
    .resolve_valid   (resolve_valid),
    .resolve_taken   (resolve_taken),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc),
    .queue_full      (queue_full),
    .pending         (pending)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    fetch_valid     = 1'b0;
    fetch_is_branch = 1'b0;
    fetch_pc        = 5'd0;
    fetch_target    = 5'd0;
    resolve_valid   = 1'b0;
    resolve_taken   = 1'b0;
  endtask

  task automatic drive_fetch(input logic [4:0] pc, input logic [4:0] tgt);
    fetch_valid     = 1'b1;
    fetch_is_branch = 1'b1;
    fetch_pc        = pc;
    fetch_target    = tgt;
  endtask

  task automatic do_reset;
    idle();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    drive_fetch(5'd7, 5'd12);
    #1;
    total++; if (predict_taken !== 1'b0) begin bad++; $display("FAIL reset_pred: got %0b want 0", predict_taken); end
    total++; if (predict_target !== 5'd8) begin bad++; $display("FAIL reset_target: got %0d want 8", predict_target); end
    total++; if (pending !== 3'd0) begin bad++; $display("FAIL reset_pending: got %0d want 0", pending); end
    total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL reset_mis: got %0b want 0", mispredict); end
    total++; if (queue_full !== 1'b0) begin bad++; $display("FAIL reset_full: got %0b want 0", queue_full); end
    total++; if (redirect_pc !== 5'd0) begin bad++; $display("FAIL reset_redir: got %0d want 0", redirect_pc); end
    idle();
  endtask

  // pc 3 resolved taken three times: counter 01 -> 10 -> 11 -> 11.
  task automatic test_training;
    logic ep [3] = '{1'b0, 1'b1, 1'b1};
    logic em [3] = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive_fetch(5'd3, 5'd10);
      #1;
      total++; if (predict_taken !== ep[i]) begin bad++; $display("FAIL train_pred[%0d]: got %0b want %0b", i, predict_taken, ep[i]); end
      tick();
      idle();
      total++; if (pending !== 3'd1) begin bad++; $display("FAIL train_push[%0d]: got %0d want 1", i, pending); end
      resolve_valid = 1'b1;
      resolve_taken = 1'b1;
      tick();
      idle();
      total++; if (mispredict !== em[i]) begin bad++; $display("FAIL train_mis[%0d]: got %0b want %0b", i, mispredict, em[i]); end
      total++; if (pending !== 3'd0) begin bad++; $display("FAIL train_pending[%0d]: got %0d want 0", i, pending); end
      if (em[i]) begin
        total++; if (redirect_pc !== 5'd10) begin bad++; $display("FAIL train_redir[%0d]: got %0d want 10", i, redirect_pc); end
      end
      tick();
      total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL train_misclr[%0d]: got %0b want 0", i, mispredict); end
    end
    drive_fetch(5'd3, 5'd10);
    #1;
    total++; if (predict_taken !== 1'b1) begin bad++; $display("FAIL train_final_pred: got %0b want 1", predict_taken); end
    total++; if (predict_target !== 5'd10) begin bad++; $display("FAIL train_final_tgt: got %0d want 10", predict_target); end
    idle();
  endtask

  // pc 31: saturate at 00, then train up, last resolve NT redirects to 31+1 = 0.
  task automatic test_saturation;
    logic tk [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic ep [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic em [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [4:0] er [5] = '{5'd0, 5'd0, 5'd4, 5'd4, 5'd0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_fetch(5'd31, 5'd4);
      #1;
      total++; if (predict_taken !== ep[i]) begin bad++; $display("FAIL sat_pred[%0d]: got %0b want %0b", i, predict_taken, ep[i]); end
      tick();
      idle();
      resolve_valid = 1'b1;
      resolve_taken = tk[i];
      tick();
      idle();
      total++; if (mispredict !== em[i]) begin bad++; $display("FAIL sat_mis[%0d]: got %0b want %0b", i, mispredict, em[i]); end
      if (em[i]) begin
        total++; if (redirect_pc !== er[i]) begin bad++; $display("FAIL sat_redir[%0d]: got %0d want %0d", i, redirect_pc, er[i]); end
      end
      tick();
    end
  endtask

  task automatic test_full;
    logic [2:0] ep [3] = '{3'd2, 3'd1, 3'd0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_fetch(5'(20 + i), 5'd0);
      tick();
    end
    idle();
    total++; if (pending !== 3'd4) begin bad++; $display("FAIL full_pending: got %0d want 4", pending); end
    total++; if (queue_full !== 1'b1) begin bad++; $display("FAIL full_flag: got %0b want 1", queue_full); end
    drive_fetch(5'd24, 5'd0);
    tick();
    idle();
    total++; if (pending !== 3'd4) begin bad++; $display("FAIL full_drop: got %0d want 4", pending); end
    // pop while full: the simultaneous push (pc 25) must still be dropped
    drive_fetch(5'd25, 5'd0);
    resolve_valid = 1'b1;
    resolve_taken = 1'b0;
    tick();
    idle();
    total++; if (pending !== 3'd3) begin bad++; $display("FAIL full_pop: got %0d want 3", pending); end
    total++; if (queue_full !== 1'b0) begin bad++; $display("FAIL full_clear: got %0b want 0", queue_full); end
    total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL full_mis: got %0b want 0", mispredict); end
    // back-to-back push and correct pop: count unchanged
    drive_fetch(5'd26, 5'd0);
    resolve_valid = 1'b1;
    resolve_taken = 1'b0;
    tick();
    idle();
    total++; if (pending !== 3'd3) begin bad++; $display("FAIL b2b_pending: got %0d want 3", pending); end
    for (int i = 0; i < 3; i++) begin
      resolve_valid = 1'b1;
      resolve_taken = 1'b0;
      tick();
      idle();
      total++; if (pending !== ep[i]) begin bad++; $display("FAIL drain[%0d]: got %0d want %0d", i, pending, ep[i]); end
      total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL drain_mis[%0d]: got %0b want 0", i, mispredict); end
    end
  endtask

  task automatic test_flush;
    do_reset();
    drive_fetch(5'd2, 5'd6);  tick();
    drive_fetch(5'd5, 5'd7);  tick();
    drive_fetch(5'd9, 5'd8);  tick();
    idle();
    total++; if (pending !== 3'd3) begin bad++; $display("FAIL flush_fill: got %0d want 3", pending); end
    drive_fetch(5'd14, 5'd1);
    resolve_valid = 1'b1;
    resolve_taken = 1'b1;
    tick();
    idle();
    total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL flush_mis: got %0b want 1", mispredict); end
    total++; if (redirect_pc !== 5'd6) begin bad++; $display("FAIL flush_redir: got %0d want 6", redirect_pc); end
    total++; if (pending !== 3'd0) begin bad++; $display("FAIL flush_pending: got %0d want 0", pending); end
    // push during the mispredict cycle is ignored
    drive_fetch(5'd15, 5'd1);
    tick();
    idle();
    total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL flush_misclr: got %0b want 0", mispredict); end
    total++; if (pending !== 3'd0) begin bad++; $display("FAIL flush_nopush: got %0d want 0", pending); end
  endtask

  task automatic test_empty_and_reset;
    do_reset();
    resolve_valid = 1'b1;
    resolve_taken = 1'b1;
    tick();
    tick();
    idle();
    total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL empty_mis: got %0b want 0", mispredict); end
    total++; if (pending !== 3'd0) begin bad++; $display("FAIL empty_pending: got %0d want 0", pending); end
    drive_fetch(5'd0, 5'd9);
    #1;
    total++; if (predict_taken !== 1'b0) begin bad++; $display("FAIL empty_notrain: got %0b want 0", predict_taken); end
    drive_fetch(5'd3, 5'd10);
    tick();
    idle();
    resolve_valid = 1'b1;
    resolve_taken = 1'b1;
    tick();
    idle();
    total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL rst_pre_mis: got %0b want 1", mispredict); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL rst_async_mis: got %0b want 0", mispredict); end
    total++; if (redirect_pc !== 5'd0) begin bad++; $display("FAIL rst_async_redir: got %0d want 0", redirect_pc); end
    total++; if (pending !== 3'd0) begin bad++; $display("FAIL rst_async_pending: got %0d want 0", pending); end
    reset = 1'b0;
    drive_fetch(5'd3, 5'd10);
    #1;
    total++; if (predict_taken !== 1'b0) begin bad++; $display("FAIL rst_table: got %0b want 0", predict_taken); end
    idle();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    do_reset();
    test_reset();
    test_training();
    test_saturation();
    test_full();
    test_flush();
    test_empty_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
